// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the parametrised SPI master.
package spi_pkg;

    // Transfer phases of the master sequencer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 16;

    // Counter widths for the default configuration: divider and sck edge index.
    localparam int DEF_DIV_W  = $clog2(DEF_CLK_DIV);
    localparam int DEF_EDGE_W = $clog2(2 * DEF_DATA_W);

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle pulse every CLK_DIV enabled cycles.
// Restarting from zero on clr_i aligns the first tick exactly CLK_DIV cycles
// after a transfer is accepted.
module spi_tick_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int                 DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]   TERM  = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // Next count: clear on request, otherwise wrap at the terminal count while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    // Divider count register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == TERM);

endmodule

// File: rtl/spi_master_param.sv
// Single-clock SPI master with CPOL/CPHA, word width and bit order set by
// parameters. sck is generated from clk through a tick-enable divider.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready=1, ss=1, sck=CPOL; waits for start
//   LEAD  | ss=0, sck=CPOL for CLK_DIV cycles (setup before first edge)
//   XFER  | sck toggles every CLK_DIV cycles, 2*DATA_W edges in total
//   TRAIL | ss=0 held for CLK_DIV cycles, then rx_valid and back to IDLE
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              ss
);

    if (DATA_W < 2) begin : g_chk_data_w
        $error("spi_master_param: DATA_W must be at least 2");
    end
    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("spi_master_param: CLK_DIV must be at least 2");
    end

    localparam int                EDGE_W    = cnt_width(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);
    localparam logic              SCK_IDLE  = (CPOL != 0);

    // First bit on the wire for the configured bit order.
    function automatic logic head_bit(input logic [DATA_W-1:0] x);
        if (MSB_FIRST != 0) begin
            return x[DATA_W-1];
        end
        return x[0];
    endfunction

    // Move the next transmit bit into the head position.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] x);
        if (MSB_FIRST != 0) begin
            return x << 1;
        end
        return x >> 1;
    endfunction

    // Insert a received bit: MSB-first fills from the LSB end, LSB-first mirrors it.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] x,
                                                   input logic            b);
        if (MSB_FIRST != 0) begin
            return {x[DATA_W-2:0], b};
        end
        return {b, x[DATA_W-1:1]};
    endfunction

    state_t             state_q, state_d;
    logic [EDGE_W-1:0]  edge_q, edge_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic [DATA_W-1:0]  rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               sck_q, sck_d;
    logic               mosi_q, mosi_d;
    logic               ss_q, ss_d;
    logic               ready_q, ready_d;

    logic               div_clr;
    logic               div_en;
    logic               tick;
    logic               is_sample_edge;

    assign div_en = (state_q != IDLE);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i   (clk),
        .reset_i (reset),
        .clr_i   (div_clr),
        .en_i    (div_en),
        .tick_o  (tick)
    );

    // Even edge indices are leading edges; CPHA picks which kind samples miso.
    assign is_sample_edge = (CPHA == 0) ? ~edge_q[0] : edge_q[0];

    // Next-state and datapath decode for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ss_d       = ss_q;
        div_clr    = 1'b0;

        unique case (state_q)
            IDLE: begin
                ss_d  = 1'b1;
                sck_d = SCK_IDLE;
                if (start) begin
                    div_clr = 1'b1;
                    tx_d    = tx_data;
                    rx_sh_d = '0;
                    edge_d  = '0;
                    ss_d    = 1'b0;
                    // With CPHA=0 the first bit must be valid before the first edge.
                    mosi_d  = (CPHA == 0) ? head_bit(tx_data) : 1'b0;
                    state_d = LEAD;
                end
            end

            LEAD: begin
                if (tick) begin
                    state_d = XFER;
                end
            end

            XFER: begin
                if (tick) begin
                    sck_d = ~sck_q;
                    if (is_sample_edge) begin
                        rx_sh_d = shift_in(rx_sh_q, miso);
                    end else if (CPHA == 0) begin
                        // Trailing edge advances to the next bit; nothing follows the last one.
                        if (edge_q != LAST_EDGE) begin
                            tx_d   = shift_out(tx_q);
                            mosi_d = head_bit(shift_out(tx_q));
                        end
                    end else begin
                        mosi_d = head_bit(tx_q);
                        tx_d   = shift_out(tx_q);
                    end

                    if (edge_q == LAST_EDGE) begin
                        sck_d   = SCK_IDLE;
                        state_d = TRAIL;
                    end else begin
                        edge_d = edge_q + 1'b1;
                    end
                end
            end

            TRAIL: begin
                if (tick) begin
                    ss_d       = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State, shift registers and registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            edge_q     <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sck_q      <= SCK_IDLE;
            mosi_q     <= 1'b0;
            ss_q       <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ss_q       <= ss_d;
            ready_q    <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign ss       = ss_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: five 8-bit instances covering the four modes and
// LSB-first, plus one 16-bit instance. Instances 0, 4 and the 16-bit one loop
// mosi back to miso; instances 1..3 talk to a behavioural slave returning 8'h3C.
module tb_spi_master_param;

    localparam int         CD         = 4;
    localparam int         CD16       = 2;
    localparam logic [7:0] SLAVE_WORD = 8'h3C;
    localparam int         LAT8       = 1 + (2 * 8 + 2) * CD;
    localparam int         LAT16      = 1 + (2 * 16 + 2) * CD16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0] start;
    logic [7:0] tx_data [5];
    logic [4:0] ready;
    logic [7:0] rx_data [5];
    logic [4:0] rx_valid;
    logic [4:0] sck;
    logic [4:0] mosi;
    logic [4:0] miso;
    logic [4:0] ss;

    logic        s16_start;
    logic [15:0] s16_tx;
    logic        s16_ready;
    logic [15:0] s16_rx;
    logic        s16_rx_valid;
    logic        s16_sck;
    logic        s16_mosi;
    logic        s16_ss;

    for (genvar g = 0; g < 5; g++) begin : gi
        localparam int P_CPOL = (g == 2 || g == 3) ? 1 : 0;
        localparam int P_CPHA = (g == 1 || g == 3) ? 1 : 0;
        localparam int P_MSB  = (g == 4) ? 0 : 1;

        logic       sl_out    = 1'b0;
        logic [7:0] sl_tx     = 8'h00;
        logic [7:0] cap_word  = 8'h00;
        time        mosi_t    = 0;
        time        edge_t    = 0;
        int         stab_seen = 0;
        int         stab_bad  = 0;

        spi_master_param #(
            .DATA_W    (8),
            .CLK_DIV   (CD),
            .CPOL      (P_CPOL),
            .CPHA      (P_CPHA),
            .MSB_FIRST (P_MSB)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start    (start[g]),
            .tx_data  (tx_data[g]),
            .ready    (ready[g]),
            .rx_data  (rx_data[g]),
            .rx_valid (rx_valid[g]),
            .sck      (sck[g]),
            .mosi     (mosi[g]),
            .miso     (miso[g]),
            .ss       (ss[g])
        );

        assign miso[g] = (g == 0 || g == 4) ? mosi[g] : sl_out;

        // Slave side: load reply on select, present first bit early when CPHA=0.
        always @(negedge ss[g]) begin
            sl_tx    = SLAVE_WORD;
            cap_word = 8'h00;
            if (P_CPHA == 0) begin
                sl_out = sl_tx[7];
                sl_tx  = sl_tx << 1;
            end
        end

        always @(mosi[g]) mosi_t = $time;

        // Slave captures mosi in time order on sample edges and drives on the others.
        always @(sck[g]) begin
            if (ss[g] == 1'b0) begin
                if ((sck[g] != (P_CPOL != 0)) == (P_CPHA == 0)) begin
                    cap_word = {cap_word[6:0], mosi[g]};
                    edge_t   = $time;
                    #1;
                    stab_seen++;
                    if (mosi_t >= edge_t) stab_bad++;
                end else begin
                    sl_out = sl_tx[7];
                    sl_tx  = sl_tx << 1;
                end
            end
        end
    end

    spi_master_param #(
        .DATA_W    (16),
        .CLK_DIV   (CD16),
        .CPOL      (0),
        .CPHA      (0),
        .MSB_FIRST (1)
    ) u_dut16 (
        .clk      (clk),
        .reset    (reset),
        .start    (s16_start),
        .tx_data  (s16_tx),
        .ready    (s16_ready),
        .rx_data  (s16_rx),
        .rx_valid (s16_rx_valid),
        .sck      (s16_sck),
        .mosi     (s16_mosi),
        .miso     (s16_mosi),
        .ss       (s16_ss)
    );

    function automatic logic cpol_of(input int g);
        return (g == 2 || g == 3);
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7 - i];
        return r;
    endfunction

    // Bits seen on mosi in time order, packed first-bit-in-MSB.
    function automatic logic [7:0] expected_wire(input int g, input logic [7:0] tx);
        return (g == 4) ? rev8(tx) : tx;
    endfunction

    function automatic logic [7:0] cap_of(input int g);
        case (g)
            0:       return gi[0].cap_word;
            1:       return gi[1].cap_word;
            2:       return gi[2].cap_word;
            3:       return gi[3].cap_word;
            default: return gi[4].cap_word;
        endcase
    endfunction

    function automatic int stab_bad_of(input int g);
        case (g)
            0:       return gi[0].stab_bad;
            1:       return gi[1].stab_bad;
            2:       return gi[2].stab_bad;
            3:       return gi[3].stab_bad;
            default: return gi[4].stab_bad;
        endcase
    endfunction

    function automatic int stab_seen_of(input int g);
        case (g)
            0:       return gi[0].stab_seen;
            1:       return gi[1].stab_seen;
            2:       return gi[2].stab_seen;
            3:       return gi[3].stab_seen;
            default: return gi[4].stab_seen;
        endcase
    endfunction

    // One transfer on an 8-bit instance; called #1 after a clk edge with the DUT ready.
    task automatic run_xfer8(input int g, input logic [7:0] tx,
                             output int lat, output int ss_low, output int edges,
                             output int mosi_hi, output logic [7:0] rx);
        logic prev_sck;
        tx_data[g] = tx;
        start[g]   = 1'b1;
        @(posedge clk); #1;
        start[g]   = 1'b0;
        tx_data[g] = ~tx;
        lat = 1; ss_low = 0; edges = 0; mosi_hi = 0;
        prev_sck = sck[g];
        while (!rx_valid[g] && lat < 500) begin
            if (!ss[g]) ss_low++;
            if (mosi[g]) mosi_hi++;
            @(posedge clk); #1;
            lat++;
            if (sck[g] != prev_sck) edges++;
            prev_sck = sck[g];
        end
        rx = rx_data[g];
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = '0;
        s16_start = 1'b0;
        s16_tx    = '0;
        for (int g = 0; g < 5; g++) tx_data[g] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (ready[g] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", g, ready[g]); end
            n_cmp++;
            if (ss[g] !== 1'b1) begin n_err++; $display("FAIL reset_ss[%0d]: got %b want 1", g, ss[g]); end
            n_cmp++;
            if (sck[g] !== cpol_of(g)) begin n_err++; $display("FAIL reset_sck[%0d]: got %b want %b", g, sck[g], cpol_of(g)); end
            n_cmp++;
            if (mosi[g] !== 1'b0) begin n_err++; $display("FAIL reset_mosi[%0d]: got %b want 0", g, mosi[g]); end
            n_cmp++;
            if (rx_valid[g] !== 1'b0) begin n_err++; $display("FAIL reset_rx_valid[%0d]: got %b want 0", g, rx_valid[g]); end
            n_cmp++;
            if (rx_data[g] !== 8'h00) begin n_err++; $display("FAIL reset_rx_data[%0d]: got %h want 00", g, rx_data[g]); end
        end
        n_cmp++;
        if ({s16_ready, s16_ss, s16_sck, s16_rx_valid} !== 4'b1100) begin
            n_err++; $display("FAIL reset_wide_ctrl: got %b want 1100", {s16_ready, s16_ss, s16_sck, s16_rx_valid});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mode0_loopback();
        int lat, ss_low, edges, mosi_hi;
        logic [7:0] rx, tx;
        run_xfer8(0, 8'hA5, lat, ss_low, edges, mosi_hi, rx);
        n_cmp++;
        if (rx !== 8'hA5) begin n_err++; $display("FAIL m0_rx: got %h want a5", rx); end
        n_cmp++;
        if (lat != LAT8) begin n_err++; $display("FAIL m0_latency: got %0d want %0d", lat, LAT8); end
        n_cmp++;
        if (edges != 16) begin n_err++; $display("FAIL m0_sck_edges: got %0d want 16", edges); end
        n_cmp++;
        if (ss_low != LAT8 - 1) begin n_err++; $display("FAIL m0_ss_low: got %0d want %0d", ss_low, LAT8 - 1); end
        n_cmp++;
        if (cap_of(0) !== 8'hA5) begin n_err++; $display("FAIL m0_wire: got %h want a5", cap_of(0)); end
        for (int k = 0; k < 3; k++) begin
            tx = 8'($urandom);
            run_xfer8(0, tx, lat, ss_low, edges, mosi_hi, rx);
            n_cmp++;
            if (rx !== tx) begin n_err++; $display("FAIL m0_rand_rx: got %h want %h", rx, tx); end
            n_cmp++;
            if (cap_of(0) !== expected_wire(0, tx)) begin n_err++; $display("FAIL m0_rand_wire: got %h want %h", cap_of(0), expected_wire(0, tx)); end
        end
    endtask

    task automatic test_modes_slave();
        int lat, ss_low, edges, mosi_hi;
        logic [7:0] rx, tx;
        for (int g = 1; g < 4; g++) begin
            for (int k = 0; k < 2; k++) begin
                tx = 8'($urandom);
                run_xfer8(g, tx, lat, ss_low, edges, mosi_hi, rx);
                n_cmp++;
                if (rx !== SLAVE_WORD) begin n_err++; $display("FAIL mode%0d_rx: got %h want %h", g, rx, SLAVE_WORD); end
                n_cmp++;
                if (cap_of(g) !== expected_wire(g, tx)) begin n_err++; $display("FAIL mode%0d_wire: got %h want %h", g, cap_of(g), expected_wire(g, tx)); end
                n_cmp++;
                if (lat != LAT8) begin n_err++; $display("FAIL mode%0d_latency: got %0d want %0d", g, lat, LAT8); end
                n_cmp++;
                if (edges != 16) begin n_err++; $display("FAIL mode%0d_sck_edges: got %0d want 16", g, edges); end
                n_cmp++;
                if (sck[g] !== cpol_of(g)) begin n_err++; $display("FAIL mode%0d_sck_idle: got %b want %b", g, sck[g], cpol_of(g)); end
            end
        end
    endtask

    task automatic test_lsb_first();
        int lat, ss_low, edges, mosi_hi;
        logic [7:0] rx, tx;
        run_xfer8(4, 8'h01, lat, ss_low, edges, mosi_hi, rx);
        n_cmp++;
        if (rx !== 8'h01) begin n_err++; $display("FAIL lsb_rx: got %h want 01", rx); end
        n_cmp++;
        if (mosi_hi != 3 * CD) begin n_err++; $display("FAIL lsb_mosi_high_cycles: got %0d want %0d", mosi_hi, 3 * CD); end
        n_cmp++;
        if (cap_of(4) !== 8'h80) begin n_err++; $display("FAIL lsb_wire: got %h want 80", cap_of(4)); end
        n_cmp++;
        if (lat != LAT8) begin n_err++; $display("FAIL lsb_latency: got %0d want %0d", lat, LAT8); end
        for (int k = 0; k < 2; k++) begin
            tx = 8'($urandom);
            run_xfer8(4, tx, lat, ss_low, edges, mosi_hi, rx);
            n_cmp++;
            if (rx !== tx) begin n_err++; $display("FAIL lsb_rand_rx: got %h want %h", rx, tx); end
            n_cmp++;
            if (cap_of(4) !== expected_wire(4, tx)) begin n_err++; $display("FAIL lsb_rand_wire: got %h want %h", cap_of(4), expected_wire(4, tx)); end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] tx, got;
        int pulses;
        tx = 8'($urandom);
        tx_data[0] = tx;
        start[0]   = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n_cmp++;
        if (ready[0] !== 1'b0) begin n_err++; $display("FAIL ign_ready_busy: got %b want 0", ready[0]); end
        pulses = 0;
        got    = 8'h00;
        for (int c = 1; c < 150; c++) begin
            if (rx_valid[0]) begin pulses++; got = rx_data[0]; end
            start[0]   = (c < 60) ? 1'($urandom_range(0, 1)) : 1'b0;
            tx_data[0] = 8'($urandom);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulses != 1) begin n_err++; $display("FAIL ign_rx_valid_count: got %0d want 1", pulses); end
        n_cmp++;
        if (got !== tx) begin n_err++; $display("FAIL ign_rx: got %h want %h", got, tx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        int lat;
        a = 8'($urandom);
        b = 8'($urandom);
        tx_data[0] = a;
        start[0]   = 1'b1;
        @(posedge clk); #1;
        tx_data[0] = b;
        lat = 1;
        while (!rx_valid[0] && lat < 500) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat != LAT8) begin n_err++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, LAT8); end
        n_cmp++;
        if (rx_data[0] !== a) begin n_err++; $display("FAIL b2b_first_rx: got %h want %h", rx_data[0], a); end
        n_cmp++;
        if (ss[0] !== 1'b1) begin n_err++; $display("FAIL b2b_ss_gap: got %b want 1", ss[0]); end
        @(posedge clk); #1;
        start[0] = 1'b0;
        n_cmp++;
        if (ss[0] !== 1'b0) begin n_err++; $display("FAIL b2b_ss_reasserted: got %b want 0", ss[0]); end
        n_cmp++;
        if (ready[0] !== 1'b0) begin n_err++; $display("FAIL b2b_ready: got %b want 0", ready[0]); end
        lat = 1;
        while (!rx_valid[0] && lat < 500) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat != LAT8) begin n_err++; $display("FAIL b2b_second_latency: got %0d want %0d", lat, LAT8); end
        n_cmp++;
        if (rx_data[0] !== b) begin n_err++; $display("FAIL b2b_second_rx: got %h want %h", rx_data[0], b); end
    endtask

    task automatic test_reset_mid();
        int edges, cyc, pulses;
        logic prev_sck;
        tx_data[0] = 8'($urandom);
        start[0]   = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        edges    = 0;
        cyc      = 0;
        prev_sck = sck[0];
        while (edges < 5 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            if (sck[0] != prev_sck) edges++;
            prev_sck = sck[0];
        end
        n_cmp++;
        if (edges != 5) begin n_err++; $display("FAIL rst_mid_reach_edge5: got %0d edges want 5", edges); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (ss[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_ss: got %b want 1", ss[0]); end
        n_cmp++;
        if (sck[0] !== 1'b0) begin n_err++; $display("FAIL rst_mid_sck: got %b want 0", sck[0]); end
        n_cmp++;
        if (ready[0] !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b want 1", ready[0]); end
        pulses = 0;
        for (int c = 0; c < 100; c++) begin
            if (rx_valid[0]) pulses++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (pulses != 0) begin n_err++; $display("FAIL rst_mid_rx_valid: got %0d pulses want 0", pulses); end
        n_cmp++;
        if (rx_data[0] !== 8'h00) begin n_err++; $display("FAIL rst_mid_rx_data: got %h want 00", rx_data[0]); end
    endtask

    task automatic test_wide();
        logic [15:0] tx;
        int lat, ss_low;
        for (int k = 0; k < 2; k++) begin
            tx = (k == 0) ? 16'hBEEF : 16'($urandom);
            s16_tx    = tx;
            s16_start = 1'b1;
            @(posedge clk); #1;
            s16_start = 1'b0;
            s16_tx    = ~tx;
            lat    = 1;
            ss_low = 0;
            while (!s16_rx_valid && lat < 500) begin
                if (!s16_ss) ss_low++;
                @(posedge clk); #1;
                lat++;
            end
            n_cmp++;
            if (s16_rx !== tx) begin n_err++; $display("FAIL wide_rx: got %h want %h", s16_rx, tx); end
            n_cmp++;
            if (lat != LAT16) begin n_err++; $display("FAIL wide_latency: got %0d want %0d", lat, LAT16); end
            n_cmp++;
            if (ss_low != LAT16 - 1) begin n_err++; $display("FAIL wide_ss_low: got %0d want %0d", ss_low, LAT16 - 1); end
        end
    endtask

    task automatic test_mosi_stability();
        for (int g = 0; g < 5; g++) begin
            n_cmp++;
            if (stab_seen_of(g) == 0) begin n_err++; $display("FAIL stab_seen[%0d]: got 0 sample edges want >0", g); end
            n_cmp++;
            if (stab_bad_of(g) != 0) begin n_err++; $display("FAIL mosi_stable[%0d]: got %0d unstable samples want 0", g, stab_bad_of(g)); end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_modes_slave();
        test_lsb_first();
        test_ignore_start();
        test_back_to_back();
        test_wide();
        test_mosi_stability();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
